// File: rtl/fixed_point_dispatch_pkg.sv
// Shared op codes, dispatcher state encodings and helpers for fixed_point_dispatch.
package fxp_defs;

  typedef enum logic [1:0] {
    FXP_ADD  = 2'd0,
    FXP_SUB  = 2'd1,
    FXP_MUL  = 2'd2,
    FXP_SQRT = 2'd3
  } fxp_op_e;

  typedef enum logic [1:0] {
    DISP_IDLE  = 2'd0,
    DISP_CLEAR = 2'd1,
    DISP_WAIT  = 2'd2,
    DISP_WB    = 2'd3
  } disp_state_e;

  // Ops whose ready is sticky inside the unit and must be cleared before issue.
  function automatic logic is_multi_cycle(input fxp_op_e op);
    return (op == FXP_MUL) || (op == FXP_SQRT);
  endfunction

endpackage

// File: rtl/fixed_point_dispatch_watchdog.sv
// WAIT-state cycle counter for fixed_point_dispatch; only built with FXP_DISPATCH_TIMEOUT_EN.
module fxp_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT-th counted cycle so the abort lands on that cycle's closing edge.
  assign expired_o = start_i && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fixed_point_dispatch.sv
// Issue/writeback sequencer for the fixed-point unit; FXP_DISPATCH_TIMEOUT_EN adds a WAIT watchdog.
module fixed_point_dispatch
  import fxp_defs::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FBITS   = 10,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned RD_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [RD_W-1:0]  req_rd_i,
  output logic [WIDTH-1:0] fpu_operand_1_o,
  output logic [WIDTH-1:0] fpu_operand_2_o,
  output logic [1:0]       fpu_operation_o,
  output logic             fpu_clear_o,
  input  logic [WIDTH-1:0] fpu_result_i,
  input  logic             fpu_ready_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [WIDTH-1:0] wb_data_o,
  output logic [RD_W-1:0]  wb_rd_o,
  output logic             wb_err_o,
  output logic             busy_o
);

  disp_state_e      state_q, state_d;
  fxp_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic             clear_q, clear_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
  logic             wb_err_q, wb_err_d;
  logic             wd_expired;

  logic unused_fbits;
  assign unused_fbits = (FBITS != 0);

`ifdef FXP_DISPATCH_TIMEOUT_EN
  fxp_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .start_i  (state_q == DISP_WAIT),
    .clear_i  (state_q != DISP_WAIT),
    .expired_o(wd_expired)
  );
  assign wb_err_o = wb_err_q;
`else
  logic unused_wd;
  assign unused_wd  = wb_err_q ^ (TIMEOUT != 0);
  assign wd_expired = 1'b0;
  assign wb_err_o   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    clear_d   = 1'b0;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_err_d  = wb_err_q;
    case (state_q)
      DISP_IDLE: begin
        if (req_valid_i) begin
          a_d  = req_a_i;
          b_d  = req_b_i;
          op_d = fxp_op_e'(req_op_i);
          rd_d = req_rd_i;
          if (is_multi_cycle(fxp_op_e'(req_op_i))) begin
            state_d = DISP_CLEAR;
            clear_d = 1'b1;
          end else begin
            state_d = DISP_WAIT;
          end
        end
      end
      // Ready seen here is the stale flag from the previous op; the clear pulse drops it.
      DISP_CLEAR: state_d = DISP_WAIT;
      DISP_WAIT: begin
        if (fpu_ready_i) begin
          wb_data_d = fpu_result_i;
          wb_rd_d   = rd_q;
          wb_err_d  = 1'b0;
          op_d      = FXP_ADD;
          state_d   = DISP_WB;
        end else if (wd_expired) begin
          wb_data_d = '0;
          wb_rd_d   = rd_q;
          wb_err_d  = 1'b1;
          op_d      = FXP_ADD;
          clear_d   = 1'b1;
          state_d   = DISP_WB;
        end
      end
      DISP_WB: begin
        if (wb_ready_i) state_d = DISP_IDLE;
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DISP_IDLE;
      op_q      <= FXP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      clear_q   <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      clear_q   <= clear_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign req_ready_o     = (state_q == DISP_IDLE);
  assign busy_o          = (state_q != DISP_IDLE);
  assign wb_valid_o      = (state_q == DISP_WB);
  assign fpu_operand_1_o = a_q;
  assign fpu_operand_2_o = b_q;
  assign fpu_operation_o = op_q;
  assign fpu_clear_o     = clear_q;
  assign wb_data_o       = wb_data_q;
  assign wb_rd_o         = wb_rd_q;

endmodule

// File: tb/tb_fixed_point_dispatch.sv
// Self-checking bench for fixed_point_dispatch with a behavioural fixed-point unit model.
module tb_fixed_point_dispatch;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned FBITS   = 10;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned RD_W    = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [WIDTH-1:0] req_a = '0, req_b = '0;
  logic [RD_W-1:0]  req_rd = '0;
  logic [WIDTH-1:0] fpu_operand_1, fpu_operand_2, fpu_result;
  logic [1:0]       fpu_operation;
  logic             fpu_clear, fpu_ready;
  logic             wb_valid, wb_err, busy;
  logic             wb_ready = 1'b0;
  logic [WIDTH-1:0] wb_data;
  logic [RD_W-1:0]  wb_rd;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_point_dispatch #(
    .WIDTH(WIDTH), .FBITS(FBITS), .TIMEOUT(TIMEOUT), .RD_W(RD_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_rd_i(req_rd),
    .fpu_operand_1_o(fpu_operand_1), .fpu_operand_2_o(fpu_operand_2),
    .fpu_operation_o(fpu_operation), .fpu_clear_o(fpu_clear),
    .fpu_result_i(fpu_result), .fpu_ready_i(fpu_ready),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data),
    .wb_rd_o(wb_rd), .wb_err_o(wb_err), .busy_o(busy)
  );

  // Reference arithmetic in Q(32-FBITS).FBITS.
  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [63:0] r, t;
    r = '0;
    for (int k = 31; k >= 0; k--) begin
      t = r | (64'd1 << k);
      if (t * t <= v) r = t;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint p;
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> FBITS;
        return p[31:0];
      end
      default: return isqrt({32'd0, a} << FBITS);
    endcase
  endfunction

  // Unit model: ADD/SUB answer combinationally; MUL/SQRT start on fpu_clear, ready sticks.
  logic [31:0] m_res_q  = '0;
  logic        m_done_q = 1'b0;
  logic        m_pend_q = 1'b0;
  int          m_cnt_q  = 0;
  int          m_lat    = 2;
  logic        m_stuck  = 1'b0;

  always_comb begin
    fpu_ready  = 1'b0;
    fpu_result = m_res_q;
    if (fpu_operation < 2'd2) begin
      fpu_ready  = 1'b1;
      fpu_result = ref_result(fpu_operation, fpu_operand_1, fpu_operand_2);
    end else begin
      fpu_ready = m_done_q;
    end
    if (m_stuck) fpu_ready = 1'b0;
  end

  always @(posedge clk) begin
    if (fpu_clear) begin
      m_done_q <= 1'b0;
      m_pend_q <= 1'b1;
      m_cnt_q  <= m_lat - 1;
      m_res_q  <= ref_result(fpu_operation, fpu_operand_1, fpu_operand_2);
    end else if (m_pend_q) begin
      if (m_cnt_q == 0) begin
        m_done_q <= 1'b1;
        m_pend_q <= 1'b0;
      end else begin
        m_cnt_q <= m_cnt_q - 1;
      end
    end
  end

  // Drives one request through the handshakes and reports what was observed; no checking here.
  task automatic do_issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold, input int budget,
                          output bit done, output int lat, output logic [31:0] data,
                          output logic [4:0] rdo, output logic err, output int clr_cnt,
                          output logic clr_first, output logic [1:0] op_after,
                          output int hold_bad, output logic rdy_after, output int acc_cyc);
    int waited;
    done = 1'b0; lat = 0; data = '0; rdo = '0; err = 1'b0; clr_cnt = 0; clr_first = 1'b0;
    op_after = '0; hold_bad = 0; rdy_after = 1'b0; acc_cyc = 0; waited = 0;
    wb_ready = (hold == 0);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0; req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
    req_rd = 5'($urandom);
    lat = 1;
    @(negedge clk);
    clr_first = fpu_clear;
    if (fpu_clear) clr_cnt++;
    while (!wb_valid && lat < budget) begin
      @(negedge clk);
      lat++;
      if (fpu_clear) clr_cnt++;
    end
    if (!wb_valid) return;
    done = 1'b1; data = wb_data; rdo = wb_rd; err = wb_err; op_after = fpu_operation;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!wb_valid || wb_data !== data || wb_rd !== rdo || wb_err !== err || req_ready || !busy)
        hold_bad++;
    end
    wb_ready = 1'b1;
    @(negedge clk);
    rdy_after = req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b want 0", wb_valid); else n_pass++;
    n_checks++; if (wb_err !== 1'b0) $display("FAIL rst_wb_err: got %b want 0", wb_err); else n_pass++;
    n_checks++; if (wb_data !== 32'd0) $display("FAIL rst_wb_data: got %h want 0", wb_data); else n_pass++;
    n_checks++; if (wb_rd !== 5'd0) $display("FAIL rst_wb_rd: got %h want 0", wb_rd); else n_pass++;
    n_checks++; if ({fpu_operand_1, fpu_operand_2} !== 64'd0) $display("FAIL rst_operands: got %h want 0", {fpu_operand_1, fpu_operand_2}); else n_pass++;
    n_checks++; if (fpu_operation !== 2'd0) $display("FAIL rst_operation: got %0d want 0", fpu_operation); else n_pass++;
    n_checks++; if (fpu_clear !== 1'b0) $display("FAIL rst_clear: got %b want 0", fpu_clear); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL post_rst_idle: got rdy=%b busy=%b want 1/0", req_ready, busy); else n_pass++;
  endtask

  task automatic test_add_sub();
    bit d; int lat, cc, hb, ac; logic [31:0] data; logic [4:0] rdo; logic err, cf, ra; logic [1:0] oa;
    do_issue(2'd0, 32'h600, 32'h900, 5'd7, 0, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (!d || lat !== 2) $display("FAIL add_latency: got done=%b lat=%0d want 1/2", d, lat); else n_pass++;
    n_checks++; if (data !== 32'h00000F00) $display("FAIL add_data: got %h want 00000f00", data); else n_pass++;
    n_checks++; if (rdo !== 5'd7 || err !== 1'b0) $display("FAIL add_rd_err: got rd=%0d err=%b want 7/0", rdo, err); else n_pass++;
    n_checks++; if (cc !== 0) $display("FAIL add_no_clear: got %0d pulses want 0", cc); else n_pass++;
    do_issue(2'd1, 32'h400, 32'h800, 5'd3, 0, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (!d || lat !== 2) $display("FAIL sub_latency: got done=%b lat=%0d want 1/2", d, lat); else n_pass++;
    n_checks++; if (data !== 32'hFFFFFC00 || rdo !== 5'd3) $display("FAIL sub_data: got %h rd=%0d want fffffc00/3", data, rdo); else n_pass++;
  endtask

  task automatic test_mul_stale();
    bit d; int lat, cc, hb, ac; logic [31:0] data; logic [4:0] rdo; logic err, cf, ra; logic [1:0] oa;
    m_lat = 3;
    do_issue(2'd2, 32'h800, 32'h400, 5'd1, 0, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (!d || data !== 32'h00000800) $display("FAIL mul_prior_data: got done=%b %h want 1/00000800", d, data); else n_pass++;
    m_lat = 2;
    do_issue(2'd2, 32'h600, 32'h600, 5'd9, 0, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (cf !== 1'b1 || cc !== 1) $display("FAIL mul_clear_pulse: got first=%b count=%0d want 1/1", cf, cc); else n_pass++;
    n_checks++; if (!d || lat !== 5) $display("FAIL mul_latency: got done=%b lat=%0d want 1/5", d, lat); else n_pass++;
    n_checks++; if (data !== 32'h00000900 || rdo !== 5'd9) $display("FAIL mul_data: got %h rd=%0d want 00000900/9", data, rdo); else n_pass++;
    n_checks++; if (oa !== 2'd0) $display("FAIL mul_op_after: got %0d want 0", oa); else n_pass++;
  endtask

  task automatic test_sqrt_hold();
    bit d; int lat, cc, hb, ac; logic [31:0] data; logic [4:0] rdo; logic err, cf, ra; logic [1:0] oa;
    m_lat = 4;
    do_issue(2'd3, 32'h1000, $urandom, 5'd17, 5, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (!d || data !== 32'h00000800) $display("FAIL sqrt_data: got done=%b %h want 1/00000800", d, data); else n_pass++;
    n_checks++; if (lat !== 7) $display("FAIL sqrt_latency: got %0d want 7", lat); else n_pass++;
    n_checks++; if (hb !== 0) $display("FAIL sqrt_hold_stable: got %0d bad cycles want 0", hb); else n_pass++;
    n_checks++; if (ra !== 1'b1) $display("FAIL sqrt_ready_after: got %b want 1", ra); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit d; int lat, cc, hb, ac0, ac1; logic [31:0] data; logic [4:0] rdo; logic err, cf, ra;
    logic [1:0] oa;
    do_issue(2'd0, 32'd5, 32'd6, 5'd2, 0, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac0);
    do_issue(2'd1, 32'd9, 32'd4, 5'd4, 0, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac1);
    n_checks++; if (ac1 - ac0 !== 3) $display("FAIL b2b_interval: got %0d want 3", ac1 - ac0); else n_pass++;
    n_checks++; if (data !== 32'd5) $display("FAIL b2b_data: got %h want 5", data); else n_pass++;
  endtask

  task automatic test_timeout();
    bit d; int lat, cc, hb, ac; logic [31:0] data; logic [4:0] rdo; logic err, cf, ra; logic [1:0] oa;
    m_stuck = 1'b1;
    m_lat = 2;
`ifdef FXP_DISPATCH_TIMEOUT_EN
    do_issue(2'd2, 32'h600, 32'h600, 5'd11, 0, 200, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (!d || lat !== TIMEOUT + 2) $display("FAIL wd_latency: got done=%b lat=%0d want 1/%0d", d, lat, TIMEOUT + 2); else n_pass++;
    n_checks++; if (err !== 1'b1 || data !== 32'd0) $display("FAIL wd_err_data: got err=%b data=%h want 1/0", err, data); else n_pass++;
    n_checks++; if (cc - int'(cf) !== 1) $display("FAIL wd_abort_clear: got %0d pulses want 1", cc - int'(cf)); else n_pass++;
    m_stuck = 1'b0;
`else
    do_issue(2'd2, 32'h600, 32'h600, 5'd11, 0, 100, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (d !== 1'b0 || wb_valid !== 1'b0) $display("FAIL nowd_no_wb: got done=%b wb_valid=%b want 0/0", d, wb_valid); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL nowd_busy: got %b want 1", busy); else n_pass++;
    m_stuck = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_wait();
    bit d; int lat, cc, hb, ac; logic [31:0] data; logic [4:0] rdo; logic err, cf, ra; logic [1:0] oa;
    m_lat = 40;
    do_issue(2'd2, 32'h1234, 32'h5678, 5'd21, 0, 4, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (busy !== 1'b1 || d !== 1'b0) $display("FAIL mid_in_wait: got busy=%b done=%b want 1/0", busy, d); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL async_rst_state: got rdy=%b busy=%b want 1/0", req_ready, busy); else n_pass++;
    n_checks++; if (fpu_operation !== 2'd0 || fpu_clear !== 1'b0) $display("FAIL async_rst_fpu: got op=%0d clr=%b want 0/0", fpu_operation, fpu_clear); else n_pass++;
    n_checks++; if ({fpu_operand_1, fpu_operand_2} !== 64'd0) $display("FAIL async_rst_operands: got %h want 0", {fpu_operand_1, fpu_operand_2}); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0 || wb_err !== 1'b0) $display("FAIL async_rst_wb: got v=%b d=%h rd=%0d e=%b want all 0", wb_valid, wb_data, wb_rd, wb_err); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_issue(2'd0, 32'd1, 32'd2, 5'd6, 0, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
    n_checks++; if (!d || data !== 32'd3 || rdo !== 5'd6) $display("FAIL post_rst_add: got done=%b %h rd=%0d want 1/3/6", d, data, rdo); else n_pass++;
  endtask

  task automatic test_random();
    bit d; int lat, cc, hb, ac, hold, exp_lat; logic [31:0] data, a, b, exp; logic [4:0] rdo, rd;
    logic err, cf, ra; logic [1:0] oa, op;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; rd = 5'($urandom);
      m_lat = $urandom_range(1, 8); hold = $urandom_range(0, 3);
      exp = ref_result(op, a, b);
      exp_lat = (op < 2'd2) ? 2 : 3 + m_lat;
      do_issue(op, a, b, rd, hold, 40, d, lat, data, rdo, err, cc, cf, oa, hb, ra, ac);
      n_checks++; if (!d || lat !== exp_lat) $display("FAIL rnd%0d_latency: got done=%b lat=%0d want 1/%0d", i, d, lat, exp_lat); else n_pass++;
      n_checks++; if (data !== exp) $display("FAIL rnd%0d_data: op=%0d got %h want %h", i, op, data, exp); else n_pass++;
      n_checks++; if (rdo !== rd || err !== 1'b0) $display("FAIL rnd%0d_rd_err: got rd=%0d err=%b want %0d/0", i, rdo, err, rd); else n_pass++;
      n_checks++; if (hb !== 0 || ra !== 1'b1) $display("FAIL rnd%0d_handshake: got bad=%0d rdy=%b want 0/1", i, hb, ra); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_mul_stale();
    test_sqrt_hold();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
